ap_hs_txn_tracker: RTL and testbench
====================================

# ap_hs_txn_tracker

Synthesizable transaction tracker for one ap_ctrl_hs block-level handshake. It turns the ap_start/ap_ready/ap_done/ap_continue activity of a monitored module into per-transaction records of start timestamp, latency, start-to-start interval and sequence number. It sits directly upstream of the module-status dump path and buffers records in a small FIFO behind a valid/ready port. Records are consumed at the sample rate rather than the handshake rate.

## Interface
- TS_W, 32: width of cycle counter, timestamps, latency and interval.
- QDEPTH, 4: outstanding-start queue depth (power of 2, ≥2).
- RDEPTH, 8: record FIFO depth (power of 2, ≥2).
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ap_start  in  1  monitored module start.
- ap_ready  in  1  monitored module ready.
- ap_done  in  1  monitored module done.
- ap_continue  in  1  monitored module continue (tie 1 when unused).
- finish  in  1  end of run; enters drain.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts record.
- rec_start_ts  out  TS_W  cycle of accepted start.
- rec_latency  out  TS_W  done cycle minus start cycle.
- rec_interval  out  TS_W  this start minus previous start, 0 for first.
- rec_seq  out  16  transaction index, first = 0, wraps.
- drop_cnt  out  16  records lost to full FIFO, saturating.
- err_start_ovf  out  1  sticky: start seen with start queue full.
- err_orphan_done  out  1  sticky: done seen with no outstanding start.
- quiesced  out  1  drain complete.

## Operation
- Reset (reset=0) clears all state. All outputs are 0 while reset is low, counter=0, state=RUN.
- Free-running cycle counter: 0 in the first cycle after reset release, +1 per cycle, wraps mod 2^TS_W.
- Start accept: ap_start & ap_ready, in RUN only.
  - Push counter value into the start queue.
  - Interval = counter − previous accepted start, mod 2^TS_W. Forced to 0 for the first start since reset.
  - Start queue full and no done in the same cycle: start is not recorded, err_start_ovf=1, previous-start register is not updated.
- Done: ap_done & ap_continue, in RUN or DRAIN.
  - Pop the oldest queue entry, latency = counter − entry, mod 2^TS_W.
  - Push {start_ts, latency, interval, seq} into the record FIFO, then seq+1.
  - Queue empty but a start is accepted in the same cycle: pair with that start, latency=0.
  - Queue empty with no same-cycle start: no record, err_orphan_done=1.
- Simultaneous start and done with a full queue: pop and push both happen, no error.
- Record FIFO full at push (and no pop that cycle): record dropped, drop_cnt+1 (saturates at 0xFFFF), seq still increments.
- Record FIFO is first-word-fall-through. The head is on rec_*. The entry is popped when rec_valid & rec_ready.
- State machine:
  - RUN → DRAIN on finish=1.
  - DRAIN: starts ignored, dones and record output still serviced. → DONE when the start queue and record FIFO are both empty.
  - DONE: quiesced=1, all handshake inputs ignored, rec_valid=0. Exit only by reset.
- Sticky flags clear only on reset.

## Timing
- Handshakes are sampled on the rising edge. The timestamp is the counter value in the cycle the handshake is high.
- Done-to-rec_valid latency is 1 cycle when the FIFO was empty.
- Back-to-back dones each cycle are sustained at full rate while rec_ready=1.
- rec_* hold stable while rec_valid=1 and rec_ready=0.
- quiesced rises 1 cycle after the last record is popped (or the cycle after finish if nothing is pending).
- Reset asserted mid-operation: outputs clear immediately (asynchronous). All queued transactions are discarded.

## Test plan
- Single transaction: start accepted at counter 5, done at 12, rec_ready=1 → one record {5,7,0,seq 0}, rec_valid high in cycle 13 only.
- Pipelined overlap: starts at 3,4,5, dones at 9,10,11 → records latency 6,6,6, intervals 0,1,1, seq 0,1,2.
- Same-cycle start+done with empty queue at counter 20 → record {20,0,…}, no error. Done alone at 30 with empty queue → err_orphan_done=1, no record.
- Backpressure: rec_ready=0, 10 transactions with RDEPTH=8 → 8 records held stable, drop_cnt=2. Then rec_ready=1 → 8 records drain with seq 0..7.
- Start queue overflow: QDEPTH=4, 5 starts, no done → err_start_ovf=1. Later 4 dones → 4 records.
- Finish with 2 outstanding: starts after finish ignored, both dones recorded, quiesced=1 after the last pop. Reset pulse mid-drain → all outputs 0, state RUN.

Source files
------------

// File: rtl/ap_hs_txn_tracker.sv
// Transaction tracker for one ap_ctrl_hs handshake: pairs accepted starts with dones
// and emits {start_ts, latency, interval, seq} records through a FWFT valid/ready FIFO.
module ap_hs_txn_tracker #(
    parameter int unsigned TS_W   = 32,
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned RDEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_continue,
    input  logic              finish,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [TS_W-1:0]   rec_start_ts,
    output logic [TS_W-1:0]   rec_latency,
    output logic [TS_W-1:0]   rec_interval,
    output logic [15:0]       rec_seq,
    output logic [15:0]       drop_cnt,
    output logic              err_start_ovf,
    output logic              err_orphan_done,
    output logic              quiesced
);

    localparam int unsigned QAW = $clog2(QDEPTH);
    localparam int unsigned RAW = $clog2(RDEPTH);
    localparam int unsigned QCW = QAW + 1;
    localparam int unsigned RCW = RAW + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [TS_W-1:0] lat;
        logic [TS_W-1:0] iv;
        logic [15:0]     seq;
    } rec_t;

    state_t          state;
    state_t          state_nxt;

    logic [TS_W-1:0] counter;
    logic [TS_W-1:0] prev_start;
    logic            have_prev;
    logic [15:0]     seq;

    logic [TS_W-1:0] q_ts [QDEPTH];
    logic [TS_W-1:0] q_iv [QDEPTH];
    logic [QAW-1:0]  q_wr;
    logic [QAW-1:0]  q_rd;
    logic [QCW-1:0]  q_cnt;
    logic [QCW-1:0]  q_cnt_nxt;

    rec_t            r_mem [RDEPTH];
    logic [RAW-1:0]  r_wr;
    logic [RAW-1:0]  r_rd;
    logic [RCW-1:0]  r_cnt;
    logic [RCW-1:0]  r_cnt_nxt;

    logic            start_acc;
    logic            done_ev;
    logic            q_empty;
    logic            q_full;
    logic [TS_W-1:0] cur_iv;
    logic            q_push;
    logic            q_pop;
    logic            start_rec;
    logic            orphan;
    logic            ovf;
    logic            gen;
    rec_t            gen_rec;
    logic            r_full;
    logic            r_push;
    logic            r_pop;
    logic            drop;
    logic            drained;

    // Handshake decode: decide queue push/pop and whether a record is produced.
    always_comb begin
        start_acc    = ap_start & ap_ready & (state == RUN);
        done_ev      = ap_done & ap_continue & (state != DONE);
        q_empty      = (q_cnt == '0);
        q_full       = (q_cnt == QCW'(QDEPTH));
        cur_iv       = have_prev ? (counter - prev_start) : '0;
        q_push       = 1'b0;
        q_pop        = 1'b0;
        start_rec    = 1'b0;
        orphan       = 1'b0;
        ovf          = 1'b0;
        gen          = 1'b0;
        gen_rec      = '0;
        gen_rec.seq  = seq;
        if (done_ev) begin
            if (!q_empty) begin
                q_pop       = 1'b1;
                gen         = 1'b1;
                gen_rec.ts  = q_ts[q_rd];
                gen_rec.lat = counter - q_ts[q_rd];
                gen_rec.iv  = q_iv[q_rd];
                // The pop frees a slot, so a same-cycle start always fits.
                if (start_acc) begin
                    q_push    = 1'b1;
                    start_rec = 1'b1;
                end
            end else if (start_acc) begin
                gen         = 1'b1;
                start_rec   = 1'b1;
                gen_rec.ts  = counter;
                gen_rec.lat = '0;
                gen_rec.iv  = cur_iv;
            end else begin
                orphan = 1'b1;
            end
        end else if (start_acc) begin
            if (q_full) begin
                ovf = 1'b1;
            end else begin
                q_push    = 1'b1;
                start_rec = 1'b1;
            end
        end
    end

    always_comb begin
        r_pop     = rec_valid & rec_ready;
        r_full    = (r_cnt == RCW'(RDEPTH));
        r_push    = gen & (~r_full | r_pop);
        drop      = gen & r_full & ~r_pop;
        q_cnt_nxt = q_cnt + QCW'(q_push) - QCW'(q_pop);
        r_cnt_nxt = r_cnt + RCW'(r_push) - RCW'(r_pop);
        drained   = (q_cnt_nxt == '0) && (r_cnt_nxt == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Emptiness is judged after this cycle's traffic so quiesced rises one cycle after the last pop.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (finish) state_nxt = drained ? DONE : DRAIN;
            DRAIN:   if (drained) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        quiesced     = (state == DONE);
        rec_valid    = (r_cnt != '0) && (state != DONE);
        rec_start_ts = '0;
        rec_latency  = '0;
        rec_interval = '0;
        rec_seq      = '0;
        if (rec_valid) begin
            rec_start_ts = r_mem[r_rd].ts;
            rec_latency  = r_mem[r_rd].lat;
            rec_interval = r_mem[r_rd].iv;
            rec_seq      = r_mem[r_rd].seq;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter         <= '0;
            prev_start      <= '0;
            have_prev       <= 1'b0;
            seq             <= '0;
            q_wr            <= '0;
            q_rd            <= '0;
            q_cnt           <= '0;
            r_wr            <= '0;
            r_rd            <= '0;
            r_cnt           <= '0;
            drop_cnt        <= '0;
            err_start_ovf   <= 1'b0;
            err_orphan_done <= 1'b0;
        end else begin
            counter <= counter + 1'b1;
            if (start_rec) begin
                prev_start <= counter;
                have_prev  <= 1'b1;
            end
            if (gen) seq <= seq + 1'b1;
            if (q_push) q_wr <= q_wr + 1'b1;
            if (q_pop) q_rd <= q_rd + 1'b1;
            q_cnt <= q_cnt_nxt;
            if (r_push) r_wr <= r_wr + 1'b1;
            if (r_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt_nxt;
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
            if (ovf) err_start_ovf <= 1'b1;
            if (orphan) err_orphan_done <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (q_push) begin
            q_ts[q_wr] <= counter;
            q_iv[q_wr] <= cur_iv;
        end
        if (r_push) r_mem[r_wr] <= gen_rec;
    end

endmodule

// File: tb/tb_ap_hs_txn_tracker.sv
// Directed bench for ap_hs_txn_tracker: expected records are queued at each done and
// checked by an independent monitor on every accepted record.
module tb_ap_hs_txn_tracker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_ready = 1'b1;
    logic        ap_done = 1'b0;
    logic        ap_continue = 1'b1;
    logic        finish = 1'b0;
    logic        rec_ready = 1'b1;
    logic        rec_valid;
    logic [31:0] rec_start_ts;
    logic [31:0] rec_latency;
    logic [31:0] rec_interval;
    logic [15:0] rec_seq;
    logic [15:0] drop_cnt;
    logic        err_start_ovf;
    logic        err_orphan_done;
    logic        quiesced;
    logic        any_out;

    ap_hs_txn_tracker #(.TS_W(32), .QDEPTH(4), .RDEPTH(8)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .finish(finish), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_start_ts(rec_start_ts), .rec_latency(rec_latency), .rec_interval(rec_interval),
        .rec_seq(rec_seq), .drop_cnt(drop_cnt), .err_start_ovf(err_start_ovf),
        .err_orphan_done(err_orphan_done), .quiesced(quiesced)
    );

    assign any_out = rec_valid | (|rec_start_ts) | (|rec_latency) | (|rec_interval) | (|rec_seq)
                   | (|drop_cnt) | err_start_ovf | err_orphan_done | quiesced;

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ts;
        logic [31:0] lat;
        logic [31:0] iv;
        logic [15:0] seq;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned t = 0;

    always @(negedge clock) begin
        if (reset && rec_valid && rec_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rec_unexpected: got ts=%0d lat=%0d iv=%0d seq=%0d, expected no record",
                         rec_start_ts, rec_latency, rec_interval, rec_seq);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rec_start_ts, rec_latency, rec_interval, rec_seq} !==
                    {mon_e.ts, mon_e.lat, mon_e.iv, mon_e.seq}) begin
                    errors++;
                    $display("FAIL rec_fields: got ts=%0d lat=%0d iv=%0d seq=%0d, expected ts=%0d lat=%0d iv=%0d seq=%0d",
                             rec_start_ts, rec_latency, rec_interval, rec_seq,
                             mon_e.ts, mon_e.lat, mon_e.iv, mon_e.seq);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] ts, input logic [31:0] lat, input logic [31:0] iv,
                        input logic [15:0] sq);
        exp_t e;
        e.ts = ts; e.lat = lat; e.iv = iv; e.seq = sq;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic at(input int unsigned n);
        while (cyc < n) step();
    endtask

    task automatic drive(input logic s, input logic d);
        ap_start = s;
        ap_done  = d;
        step();
        ap_start = 1'b0;
        ap_done  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Leaves the bench just after reset release; the next sampled cycle has counter 0.
    task automatic do_reset();
        reset = 1'b0;
        ap_start = 1'b0; ap_done = 1'b0; finish = 1'b0;
        ap_ready = 1'b1; ap_continue = 1'b1; rec_ready = 1'b1;
        exp_q.delete();
        step();
        step();
        chk("rst_outputs_zero", {31'b0, any_out}, 0);
        reset = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // single transaction; a start without ap_ready must not count
        do_reset();
        at(3); ap_ready = 1'b0; drive(1, 0); ap_ready = 1'b1;
        at(5); drive(1, 0);
        at(12); push(5, 7, 0, 0); drive(0, 1);
        chk("t1_valid_c13", {31'b0, rec_valid}, 1);
        step();
        chk("t1_valid_c14", {31'b0, rec_valid}, 0);
        wait_drain("t1_drain");

        // pipelined overlap
        do_reset();
        at(3);
        for (int i = 0; i < 3; i++) drive(1, 0);
        at(9);
        for (int i = 0; i < 3; i++) begin
            push(32'(3 + i), 6, (i == 0) ? 32'd0 : 32'd1, 16'(i));
            drive(0, 1);
        end
        wait_drain("t2_drain");

        // same-cycle start+done on empty queue, then orphan done
        do_reset();
        at(20); push(20, 0, 0, 0); drive(1, 1);
        chk("t3_no_orphan_yet", {31'b0, err_orphan_done}, 0);
        at(30); drive(0, 1);
        chk("t3_orphan", {31'b0, err_orphan_done}, 1);
        chk("t3_no_ovf", {31'b0, err_start_ovf}, 0);
        at(33); drive(1, 0);
        at(35); push(33, 2, 13, 1); drive(0, 1);
        wait_drain("t3_drain");

        // backpressure: 10 records into an 8-deep FIFO
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            at(32'(2 + 2 * i)); drive(1, 0);
            at(32'(3 + 2 * i));
            if (i < 8) push(32'(2 + 2 * i), 1, (i == 0) ? 32'd0 : 32'd2, 16'(i));
            drive(0, 1);
        end
        chk("t4_drop_cnt", {16'b0, drop_cnt}, 2);
        chk("t4_valid_held", {31'b0, rec_valid}, 1);
        chk("t4_head_ts", rec_start_ts, 2);
        repeat (3) step();
        chk("t4_head_ts_stable", rec_start_ts, 2);
        chk("t4_head_seq_stable", {16'b0, rec_seq}, 0);
        rec_ready = 1'b1;
        wait_drain("t4_drain");
        t = cyc + 2;
        at(t); drive(1, 0);
        at(t + 3); push(t, 3, t - 20, 10); drive(0, 1);
        wait_drain("t4_after_drop");
        chk("t4_drop_cnt_final", {16'b0, drop_cnt}, 2);

        // start queue overflow, then start+done with a full queue
        do_reset();
        at(2);
        repeat (4) drive(1, 0);
        chk("t5_no_ovf_yet", {31'b0, err_start_ovf}, 0);
        drive(1, 0);
        chk("t5_ovf", {31'b0, err_start_ovf}, 1);
        push(2, 5, 0, 0); drive(1, 1);
        at(10);
        push(3, 7, 1, 1); drive(0, 1);
        push(4, 7, 1, 2); drive(0, 1);
        push(5, 7, 1, 3); drive(0, 1);
        push(7, 6, 2, 4); drive(0, 1);
        chk("t5_no_orphan_yet", {31'b0, err_orphan_done}, 0);
        drive(0, 1);
        chk("t5_queue_emptied", {31'b0, err_orphan_done}, 1);
        wait_drain("t5_drain");

        // finish with two outstanding starts
        do_reset();
        at(2); drive(1, 0); drive(1, 0);
        at(5); finish = 1'b1; drive(0, 0); finish = 1'b0;
        at(6); drive(1, 0);
        at(8);
        push(2, 6, 0, 0); drive(0, 1);
        push(3, 6, 1, 1); drive(0, 1);
        chk("t6_not_quiesced", {31'b0, quiesced}, 0);
        step();
        chk("t6_quiesced", {31'b0, quiesced}, 1);
        at(12); drive(1, 1);
        chk("t6_done_no_valid", {31'b0, rec_valid}, 0);
        chk("t6_done_ignores", {31'b0, err_orphan_done}, 0);
        chk("t6_quiesced_hold", {31'b0, quiesced}, 1);
        wait_drain("t6_drain");

        // reset pulse mid-drain with a record pending
        do_reset();
        rec_ready = 1'b0;
        at(1); drive(0, 1);
        drive(1, 0); drive(1, 0);
        drive(0, 1);
        finish = 1'b1; drive(0, 0); finish = 1'b0;
        chk("t7_pending_valid", {31'b0, rec_valid}, 1);
        chk("t7_pending_lat", rec_latency, 2);
        chk("t7_orphan_set", {31'b0, err_orphan_done}, 1);
        reset = 1'b0;
        #1;
        chk("t7_async_clear", {31'b0, any_out}, 0);
        step();
        reset = 1'b1;
        cyc = 0;
        rec_ready = 1'b1;
        at(2); drive(1, 0);
        at(4); push(2, 2, 0, 0); drive(0, 1);
        wait_drain("t7_post_reset_rec");
        chk("t7_run_after_reset", {31'b0, quiesced}, 0);
        t = cyc + 1;
        at(t);
        finish = 1'b1; drive(0, 0); finish = 1'b0;
        chk("t7_quiesce_next", {31'b0, quiesced}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
